display_cronometro: RTL and testbench

//  Consumer end of the stopwatch count outputs. Takes binary seconds (0..999) and tenths (0..9) from
//  the cronometro core and drives a 4-digit multiplexed 7-segment display in "SSS.D" format.

---
 rtl/cronometro_pkg.sv | 27 ++
 rtl/bin2bcd_seq.sv | 38 +++
 rtl/display_cronometro.sv | 110 +++++++++++
 tb/tb_display_cronometro.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cronometro_pkg.sv
// cronometro_pkg: shared FSM encoding, digit indices and 7-segment glyphs for the stopwatch display
package cronometro_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [1:0] DIG_TENTHS = 2'd0;
    localparam logic [1:0] DIG_UNITS  = 2'd1;
    localparam logic [1:0] DIG_TENS   = 2'd2;
    localparam logic [1:0] DIG_HUND   = 2'd3;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
    localparam int BCD_STEPS = 10;
    // Active-low segments, a..g on bits 0..6
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 7'h40;
            4'd1: glyph = 7'h79;
            4'd2: glyph = 7'h24;
            4'd3: glyph = 7'h30;
            4'd4: glyph = 7'h19;
            4'd5: glyph = 7'h12;
            4'd6: glyph = 7'h02;
            4'd7: glyph = 7'h78;
            4'd8: glyph = 7'h00;
            4'd9: glyph = 7'h10;
            default: glyph = BLANK;
        endcase
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 10-bit binary to 3-digit BCD, one double-dabble step per clock after start
module bin2bcd_seq
    import cronometro_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);
    logic [21:0] sr_q, sr_d;
    logic [20:0] adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    // The hundreds nibble never reaches 5 before the final shift for values up to 999
    always_comb begin
        adj = sr_q[20:0];
        for (int i = 0; i < 2; i++)
            adj[10+4*i +: 4] = (sr_q[10+4*i +: 4] >= 4'd5) ? sr_q[10+4*i +: 4] + 4'd3 : sr_q[10+4*i +: 4];
        done  = run_q && cnt_q == 4'(BCD_STEPS - 1);
        run_d = start || (run_q && !done);
        cnt_d = start ? 4'd0 : run_q ? cnt_q + 4'd1 : cnt_q;
        sr_d  = start ? {12'd0, bin} : run_q ? {adj, 1'b0} : sr_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
    assign bcd = sr_q[21:10];
endmodule

// File: rtl/display_cronometro.sv
// display_cronometro: drives a 4-digit multiplexed 7-segment display as SSS.D from stopwatch counts
// Define BLANK_ZEROS_EN to blank leading zeros on the hundreds and tens digits.
module display_cronometro
    import cronometro_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [9:0] seg_in,
    input  logic [3:0] dec_in,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       busy
);
    localparam int PW = $clog2(SCAN_DIV);
    state_t        state_q, state_d;
    logic [13:0]   last_q, last_d;
    logic [3:0]    hund_q, hund_d, tens_q, tens_d, units_q, units_d, tenths_q, tenths_d;
    logic          err_q, err_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d, start, done, wrap, blank_h, blank_t;
    logic [11:0]   bcd;

    bin2bcd_seq u_bcd (.clock(clock), .reset_n(reset_n), .start(start), .bin(seg_in), .done(done), .bcd(bcd));

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        start    = 1'b0;
        hund_d   = hund_q;
        tens_d   = tens_q;
        units_d  = units_q;
        tenths_d = tenths_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if ({seg_in, dec_in} != last_q) begin
                start   = 1'b1;
                last_d  = {seg_in, dec_in};
                state_d = SHIFT;
            end
            SHIFT: if (done) state_d = DONE;
            DONE: begin
                hund_d   = bcd[11:8];
                tens_d   = bcd[7:4];
                units_d  = bcd[3:0];
                tenths_d = last_q[3:0];
                err_d    = last_q[13:4] > 10'd999 || last_q[3:0] > 4'd9;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BLANK_ZEROS_EN
    assign blank_h = hund_q == 4'd0;
    assign blank_t = blank_h && tens_q == 4'd0;
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    always_comb begin
        wrap    = presc_q == PW'(SCAN_DIV - 1);
        presc_d = wrap ? '0 : presc_q + PW'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        an_d    = ~(4'b0001 << idx_q);
        dp_d    = idx_q != DIG_UNITS;
        seg_d   = err_q ? DASH :
                  idx_q == DIG_HUND ? (blank_h ? BLANK : glyph(hund_q)) :
                  idx_q == DIG_TENS ? (blank_t ? BLANK : glyph(tens_q)) :
                  idx_q == DIG_TENTHS ? glyph(tenths_q) : glyph(units_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= '0;
            hund_q   <= '0;
            tens_q   <= '0;
            units_q  <= '0;
            tenths_q <= '0;
            err_q    <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            an_n     <= 4'hF;
            seg_n    <= BLANK;
            dp_n     <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            tenths_q <= tenths_d;
            err_q    <= err_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            an_n     <= an_d;
            seg_n    <= seg_d;
            dp_n     <= dp_d;
        end
    end

    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_display_cronometro.sv
// tb_display_cronometro: directed scoreboard bench for the SSS.D stopwatch display driver
module tb_display_cronometro;
    localparam int SCAN_DIV = 4;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [9:0] seg_in;
    logic [3:0] dec_in;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n, busy;
    int         checks = 0;
    int         errors = 0;
    logic [27:0] sb[$];

    display_cronometro #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock(clock), .reset_n(reset_n), .seg_in(seg_in), .dec_in(dec_in),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] gl(input int d);
        logic [6:0] on;
        case (d)
            0: on = 7'h3F;
            1: on = 7'h06;
            2: on = 7'h5B;
            3: on = 7'h4F;
            4: on = 7'h66;
            5: on = 7'h6D;
            6: on = 7'h7D;
            7: on = 7'h07;
            8: on = 7'h7F;
            9: on = 7'h6F;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

    // Frame packs {hundreds, tens, units, tenths} glyphs, tenths in the low 7 bits
    function automatic logic [27:0] exp_frame(input int s, input int t);
        logic [6:0] h, te, u, d;
        if (s > 999 || t > 9) return {4{7'h3F}};
        h  = gl(s / 100);
        te = gl((s / 10) % 10);
        u  = gl(s % 10);
        d  = gl(t);
`ifdef BLANK_ZEROS_EN
        if (s < 100) h = 7'h7F;
        if (s < 10) te = 7'h7F;
`endif
        return {h, te, u, d};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " an_n"}, 16'(an_n), 16'hF);
        check({tag, " seg_n"}, 16'(seg_n), 16'h7F);
        check({tag, " dp_n"}, 16'(dp_n), 16'd1);
        check({tag, " busy"}, 16'(busy), 16'd0);
    endtask

    task automatic drive(input int s, input int t);
        @(negedge clock);
        seg_in = 10'(s);
        dec_in = 4'(t);
        sb.push_back(exp_frame(s, t));
    endtask

    task automatic wait_conv(input string tag);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            check($sformatf("%s busy E%0d", tag, k), 16'(busy), 16'd1);
        end
        @(negedge clock);
        check({tag, " busy E11"}, 16'(busy), 16'd0);
    endtask

    task automatic check_frame(input string tag, input int n);
        logic [27:0] f;
        int d;
        check({tag, " sb_nonempty"}, 16'(sb.size() > 0), 16'd1);
        if (sb.size() == 0) return;
        f = sb.pop_front();
        repeat (n) begin
            @(negedge clock);
            d = an_n == 4'hE ? 0 : an_n == 4'hD ? 1 : an_n == 4'hB ? 2 : an_n == 4'h7 ? 3 : -1;
            check({tag, " an_onehot"}, 16'(d >= 0), 16'd1);
            if (d >= 0) begin
                check($sformatf("%s seg d%0d", tag, d), 16'(seg_n), 16'(f[d*7 +: 7]));
                check($sformatf("%s dp d%0d", tag, d), 16'(dp_n), 16'(d != 1));
            end
        end
    endtask

    initial begin
        logic [3:0] exp_an;
        reset_n = 1'b1;
        seg_in  = '0;
        dec_in  = '0;
        #1 reset_n = 1'b0;
        #1 check_reset("reset");
        sb.push_back(exp_frame(0, 0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
            check($sformatf("scan an_n k%0d", k), 16'(an_n), 16'(exp_an));
            check($sformatf("scan dp_n k%0d", k), 16'(dp_n), 16'((((k - 1) / 4) % 4) != 1));
        end
        check_frame("zero", 16);

        drive(347, 5);
        wait_conv("t347");
        check_frame("t347", 16);

        drive(1000, 0);
        wait_conv("t1000");
        check_frame("t1000", 16);

        drive(347, 5);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            check($sformatf("chg busy E%0d", k), 16'(busy), 16'd1);
            if (k == 4) begin
                seg_in = 10'd348;
                sb.push_back(exp_frame(348, 5));
            end
        end
        @(negedge clock);
        check("chg busy E11", 16'(busy), 16'd0);
        check_frame("chg old", 11);
        check("chg second busy", 16'(busy), 16'd1);
        @(negedge clock);
        check("chg second E11", 16'(busy), 16'd0);
        check_frame("chg new", 16);

        drive(521, 3);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clock);
            check($sformatf("rst busy E%0d", k), 16'(busy), 16'd1);
        end
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 check_reset("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        wait_conv("t521");
        check_frame("t521", 16);

        drive(7, 0);
        wait_conv("t7");
        check_frame("t7", 16);

        drive(47, 9);
        wait_conv("t47");
        check_frame("t47", 16);

        drive(5, 12);
        wait_conv("tdec");
        check_frame("tdec", 16);

        drive(0, 0);
        wait_conv("t0");
        check_frame("t0", 16);

        check("sb drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
